// File: rtl/branch_pc_sequencer.sv
// Program-counter owner: sequential advance, conditional branch redirect and multi-cycle fetch flush.
// Optional macro BRANCH_STATS_EN adds saturating taken/not-taken branch counters.
module branch_pc_sequencer #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_PC     = '0,
  parameter int unsigned      PC_STEP      = 4,
  parameter int unsigned      FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [1:0]       br_cond,
  input  logic [WIDTH-1:0] br_operand,
  input  logic [WIDTH-1:0] br_target,
  output logic             br_ready,
  output logic [WIDTH-1:0] pc_out,
  output logic             pc_valid,
  output logic             flush,
  output logic             br_taken
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]      taken_cnt,
  output logic [31:0]      not_taken_cnt
`endif
);

  localparam logic [1:0] ST_BOOT     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  localparam int unsigned      CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] STEP     = WIDTH'(PC_STEP);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pc_valid_q, pc_valid_d;
  logic             flush_q, flush_d;
  logic             br_taken_q, br_taken_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic cond_met;
  logic accept;

  // Signed tests reduce to sign bit and zero detect; the most negative value counts as less.
  always_comb begin
    cond_met = 1'b0;
    unique case (br_cond)
      2'd0: cond_met = 1'b1;
      2'd1: cond_met = br_operand[WIDTH-1];
      2'd2: cond_met = ~br_operand[WIDTH-1] & (|br_operand);
      2'd3: cond_met = ~(|br_operand);
      default: cond_met = 1'b0;
    endcase
  end

  assign br_ready = (state_q == ST_RUN) & ~stall;
  assign accept   = br_valid & br_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_valid_d = pc_valid_q;
    flush_d    = flush_q;
    br_taken_d = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      ST_BOOT: begin
        pc_valid_d = 1'b1;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        if (!stall) begin
          if (accept && cond_met) begin
            pc_d       = br_target;
            br_taken_d = 1'b1;
            flush_d    = 1'b1;
            cnt_d      = CNT_LOAD;
            state_d    = ST_REDIRECT;
          end else begin
            pc_d = pc_q + STEP;
          end
        end
      end
      ST_REDIRECT: begin
        // Counter runs regardless of stall so flush length is fixed.
        if (cnt_q == '0) begin
          flush_d = 1'b0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      br_taken_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      flush_q    <= flush_d;
      br_taken_q <= br_taken_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc_out   = pc_q;
  assign pc_valid = pc_valid_q;
  assign flush    = flush_q;
  assign br_taken = br_taken_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] taken_cnt_q, taken_cnt_d;
  logic [31:0] not_taken_cnt_q, not_taken_cnt_d;

  always_comb begin
    taken_cnt_d     = taken_cnt_q;
    not_taken_cnt_d = not_taken_cnt_q;
    if (accept) begin
      if (cond_met) begin
        if (taken_cnt_q != '1) taken_cnt_d = taken_cnt_q + 32'd1;
      end else begin
        if (not_taken_cnt_q != '1) not_taken_cnt_d = not_taken_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_cnt_q     <= '0;
      not_taken_cnt_q <= '0;
    end else begin
      taken_cnt_q     <= taken_cnt_d;
      not_taken_cnt_q <= not_taken_cnt_d;
    end
  end

  assign taken_cnt     = taken_cnt_q;
  assign not_taken_cnt = not_taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Directed bench for branch_pc_sequencer: expected per-cycle outputs queued on drive, compared after each edge.
// A second instance with RESET_PC near the top of the address space covers PC wrap.
module tb_branch_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_valid;
  logic [1:0]  br_cond;
  logic [31:0] br_operand;
  logic [31:0] br_target;
  logic        br_ready;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic        flush;
  logic        br_taken;

  logic        w_ready;
  logic [31:0] w_pc;
  logic        w_valid;
  logic        w_flush;
  logic        w_taken;

`ifdef BRANCH_STATS_EN
  logic [31:0] taken_cnt, not_taken_cnt;
  logic [31:0] w_taken_cnt, w_not_taken_cnt;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        valid;
    logic        flush;
    logic        taken;
    logic        ready;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  branch_pc_sequencer #(
    .WIDTH(32), .RESET_PC(32'h0), .PC_STEP(4), .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .br_cond(br_cond),
    .br_operand(br_operand), .br_target(br_target), .br_ready(br_ready),
    .pc_out(pc_out), .pc_valid(pc_valid), .flush(flush), .br_taken(br_taken)
`ifdef BRANCH_STATS_EN
    , .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt)
`endif
  );

  branch_pc_sequencer #(
    .WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4), .FLUSH_CYCLES(2)
  ) dut_wrap (
    .clk(clk), .rst(rst), .stall(1'b0), .br_valid(1'b0), .br_cond(2'd0),
    .br_operand(32'h0), .br_target(32'h0), .br_ready(w_ready),
    .pc_out(w_pc), .pc_valid(w_valid), .flush(w_flush), .br_taken(w_taken)
`ifdef BRANCH_STATS_EN
    , .taken_cnt(w_taken_cnt), .not_taken_cnt(w_not_taken_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Queue the expected post-edge outputs, advance one edge, then pop and compare.
  task automatic cyc(input string tag, input logic [31:0] pc, input logic v,
                     input logic f, input logic t, input logic r);
    exp_t e;
    exp_t got;
    e.tag = tag; e.pc = pc; e.valid = v; e.flush = f; e.taken = t; e.ready = r;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({got.tag, ".pc"},    pc_out,          got.pc);
    check({got.tag, ".valid"}, {31'b0, pc_valid}, {31'b0, got.valid});
    check({got.tag, ".flush"}, {31'b0, flush},    {31'b0, got.flush});
    check({got.tag, ".taken"}, {31'b0, br_taken}, {31'b0, got.taken});
    check({got.tag, ".ready"}, {31'b0, br_ready}, {31'b0, got.ready});
  endtask

  task automatic drive_br(input logic v, input logic [1:0] c,
                          input logic [31:0] op, input logic [31:0] tgt);
    br_valid = v; br_cond = c; br_operand = op; br_target = tgt;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    drive_br(1'b0, 2'd0, 32'h0, 32'h0);
    #1;
    check("rst.pc",    pc_out, 32'h0);
    check("rst.valid", {31'b0, pc_valid}, 32'h0);
    check("rst.flush", {31'b0, flush},    32'h0);
    check("rst.taken", {31'b0, br_taken}, 32'h0);
    check("rst.ready", {31'b0, br_ready}, 32'h0);
    check("rst.wpc",   w_pc, 32'hFFFF_FFFC);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Boot cycle then sequential advance; wrap instance rolls over to 0.
    cyc("boot", 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("boot.wpc", w_pc, 32'hFFFF_FFFC);
    cyc("run1", 32'h4, 1'b1, 1'b0, 1'b0, 1'b1);
    check("wrap.wpc", w_pc, 32'h0);
    cyc("run2", 32'h8, 1'b1, 1'b0, 1'b0, 1'b1);

    // Equal-zero branch taken at pc=8.
    drive_br(1'b1, 2'd3, 32'h0, 32'h100);
    #1 check("eq.rdy_pre", {31'b0, br_ready}, 32'h1);
    cyc("eq", 32'h100, 1'b1, 1'b1, 1'b1, 1'b0);
    drive_br(1'b0, 2'd0, 32'h0, 32'h0);
    cyc("eq.redir1", 32'h100, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("eq.redir2", 32'h100, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("eq.resume", 32'h104, 1'b1, 1'b0, 1'b0, 1'b1);

    // Less-than: positive operand not taken, all-ones taken.
    drive_br(1'b1, 2'd1, 32'h5, 32'h200);
    cyc("lt_pos", 32'h108, 1'b1, 1'b0, 1'b0, 1'b1);
    drive_br(1'b1, 2'd1, 32'hFFFF_FFFF, 32'h200);
    cyc("lt_neg", 32'h200, 1'b1, 1'b1, 1'b1, 1'b0);
    drive_br(1'b0, 2'd0, 32'h0, 32'h0);
    cyc("lt.redir1", 32'h200, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("lt.redir2", 32'h200, 1'b1, 1'b0, 1'b0, 1'b1);

    // Most negative operand: not greater, but less; misaligned target taken as-is.
    drive_br(1'b1, 2'd2, 32'h8000_0000, 32'h300);
    cyc("gt_min", 32'h204, 1'b1, 1'b0, 1'b0, 1'b1);
    drive_br(1'b1, 2'd1, 32'h8000_0000, 32'h301);
    cyc("lt_min", 32'h301, 1'b1, 1'b1, 1'b1, 1'b0);
    drive_br(1'b0, 2'd0, 32'h0, 32'h0);
    cyc("min.redir1", 32'h301, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("min.redir2", 32'h301, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("min.resume", 32'h305, 1'b1, 1'b0, 1'b0, 1'b1);

    // Stall holds PC and blocks acceptance of a held request.
    stall = 1'b1;
    drive_br(1'b1, 2'd0, 32'h0, 32'h400);
    #1 check("stall.rdy_pre", {31'b0, br_ready}, 32'h0);
    cyc("stall1", 32'h305, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("stall2", 32'h305, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("stall3", 32'h305, 1'b1, 1'b0, 1'b0, 1'b0);
    stall = 1'b0;
    #1 check("unstall.rdy_pre", {31'b0, br_ready}, 32'h1);
    cyc("always", 32'h400, 1'b1, 1'b1, 1'b1, 1'b0);

    // Stall during redirect does not stretch the flush.
    drive_br(1'b0, 2'd0, 32'h0, 32'h0);
    stall = 1'b1;
    cyc("sredir1", 32'h400, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("sredir2", 32'h400, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("sredir.hold", 32'h400, 1'b1, 1'b0, 1'b0, 1'b0);
    stall = 1'b0;
    cyc("sredir.resume", 32'h404, 1'b1, 1'b0, 1'b0, 1'b1);

    // Greater-than taken, then reset in the middle of the redirect.
    drive_br(1'b1, 2'd2, 32'h1, 32'h500);
    cyc("gt_pos", 32'h500, 1'b1, 1'b1, 1'b1, 1'b0);
`ifdef BRANCH_STATS_EN
    check("stats.taken",     taken_cnt,     32'd5);
    check("stats.not_taken", not_taken_cnt, 32'd2);
`endif
    drive_br(1'b0, 2'd0, 32'h0, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("midrst.flush", {31'b0, flush},    32'h0);
    check("midrst.pc",    pc_out,            32'h0);
    check("midrst.valid", {31'b0, pc_valid}, 32'h0);
    check("midrst.ready", {31'b0, br_ready}, 32'h0);
`ifdef BRANCH_STATS_EN
    check("midrst.taken_cnt",     taken_cnt,     32'd0);
    check("midrst.not_taken_cnt", not_taken_cnt, 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    cyc("reboot", 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("rerun",  32'h4, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
